// File: rtl/trng_serial_tx.sv
// Byte-serial 8N1 transmitter for the TRNG dump path. It has a single-entry holding register and RTS flow control.
// It also emits a one-cycle pulse after every FRAME_BYTES bytes sent.
module trng_serial_tx #(
  parameter int CLK_DIV     = 4,
  parameter int STOP_BITS   = 1,
  parameter int FRAME_BYTES = 256
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_dat,
  input  logic       i_write,
  input  logic       i_serial_rts_n,
  output logic       o_ready,
  output logic       o_serial_data,
  output logic       o_busy,
  output logic       o_new_frame
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BYTE_W = $clog2(FRAME_BYTES) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic                stop_q, stop_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                ready_q, ready_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                new_frame_q, new_frame_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                rts_s1_q, rts_s2_q;

  logic rts_ok, accept, baud_end, load;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    byte_cnt_d  = byte_cnt_q;
    new_frame_d = 1'b0;
    load        = 1'b0;
    rts_ok      = ~rts_s2_q;
    accept      = i_write & ready_q;
    baud_end    = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (hold_full_q && rts_ok) load = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_d  = '0;
              new_frame_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
            if (hold_full_q && rts_ok) load = 1'b1;
            else                       state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      baud_d      = '0;
      state_d     = S_START;
    end

    // A write can only be accepted while the holding register is empty, so it never races a load.
    if (accept) begin
      hold_d      = i_dat;
      hold_full_d = 1'b1;
    end

    // o_ready lags hold_full by one edge except on the write edge, where it drops at once.
    ready_d = accept ? 1'b0 : ~hold_full_q;

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      stop_q      <= 1'b0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      byte_cnt_q  <= '0;
      new_frame_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      rts_s1_q    <= 1'b1;
      rts_s2_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      byte_cnt_q  <= byte_cnt_d;
      new_frame_q <= new_frame_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      rts_s1_q    <= i_serial_rts_n;
      rts_s2_q    <= rts_s1_q;
    end
  end

  // Byte storage is qualified by hold_full/state, so it needs no reset.
  always_ff @(posedge i_clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  assign o_ready       = ready_q;
  assign o_serial_data = txd_q;
  assign o_busy        = busy_q;
  assign o_new_frame   = new_frame_q;

endmodule

// File: tb/tb_trng_serial_tx.sv
// Randomized and directed bench for trng_serial_tx against a frame-position reference model.
module tb_trng_serial_tx;

  localparam int CLK_DIV     = 4;
  localparam int STOP_BITS   = 1;
  localparam int FRAME_BYTES = 4;
  localparam int FRAME_LEN   = (9 + STOP_BITS) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dat;
  logic       write;
  logic       rts_n;
  logic       ready, line, busy, new_frame;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model: byte in flight plus cycle position inside its serial frame.
  logic       m_sync1, m_sync2, m_hold_valid, m_ready, m_active, m_pulse;
  logic [7:0] m_hold, m_byte;
  int         m_pos, m_sent;

  trng_serial_tx #(
    .CLK_DIV    (CLK_DIV),
    .STOP_BITS  (STOP_BITS),
    .FRAME_BYTES(FRAME_BYTES)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_dat         (dat),
    .i_write       (write),
    .i_serial_rts_n(rts_n),
    .o_ready       (ready),
    .o_serial_data (line),
    .o_busy        (busy),
    .o_new_frame   (new_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_line();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_sync1 = 1'b1; m_sync2 = 1'b1;
    m_hold_valid = 1'b0; m_ready = 1'b1;
    m_active = 1'b0; m_pulse = 1'b0;
    m_pos = 0; m_sent = 0;
    m_hold = 8'h00; m_byte = 8'h00;
  endtask

  task automatic model_edge();
    logic rts_ok, end_frame, can_load, accept;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rts_ok    = !m_sync2;
    end_frame = m_active && (m_pos == FRAME_LEN - 1);
    can_load  = (!m_active || end_frame) && m_hold_valid && rts_ok;
    accept    = write && m_ready;
    m_pulse   = 1'b0;
    if (end_frame) begin
      m_sent++;
      if (m_sent % FRAME_BYTES == 0) m_pulse = 1'b1;
    end
    m_ready = accept ? 1'b0 : !m_hold_valid;
    if (can_load) begin
      m_active = 1'b1; m_pos = 0; m_byte = m_hold; m_hold_valid = 1'b0;
    end else if (end_frame) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_pos++;
    end
    if (accept) begin
      m_hold = dat; m_hold_valid = 1'b1;
    end
    m_sync2 = m_sync1;
    m_sync1 = rts_n;
  endtask

  task automatic compare();
    check("line", line, exp_line());
    check("ready", ready, m_ready);
    check("busy", busy, m_active);
    check("new_frame", new_frame, m_pulse);
    if (new_frame === 1'b1) pulses++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!m_ready && n < 3000) begin
      step();
      n++;
    end
    if (!m_ready) check("send_wait", ready, 1'b1);
    write = 1'b1;
    dat   = b;
    step();
    write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_active || m_hold_valid) && n < 3000) begin
      step();
      n++;
    end
    if (m_active || m_hold_valid) check("drain_wait", busy, 1'b0);
    run(2);
  endtask

  task automatic async_reset(input int hold_cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    run(hold_cycles);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; dat = 8'h00; rts_n = 1'b1;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      write = 1'($urandom); dat = 8'($urandom); rts_n = 1'($urandom);
      step();
    end
    write = 1'b0; rts_n = 1'b0;
    rst_n = 1'b1;
    run(4);

    // Single byte
    send(8'hA5);
    run(45);

    // Back-to-back plus a third write held until ready
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    drain();

    // Flow control
    rts_n = 1'b1;
    run(4);
    send(8'h3C);
    run(100);
    rts_n = 1'b0;
    run(50);
    send(8'h96);
    run(15);
    rts_n = 1'b1;
    send(8'h69);
    run(100);
    rts_n = 1'b0;
    drain();

    // Framing: 9 bytes, FRAME_BYTES=4
    async_reset(3);
    run(3);
    pulses = 0;
    for (int i = 0; i < 9; i++) send(8'($urandom));
    drain();
    check("frame_pulses", pulses, 2);

    // Mid-byte reset during data bit 3, then byte counter restarts
    send(8'hC3);
    begin
      int n = 0;
      while (!(m_active && (m_pos / CLK_DIV) == 4) && n < 200) begin
        step();
        n++;
      end
      if (!(m_active && (m_pos / CLK_DIV) == 4)) check("bit3_wait", busy, 1'b1);
    end
    step();
    async_reset(3);
    pulses = 0;
    send(8'h81);
    run(45);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    drain();
    check("restart_pulses", pulses, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) rts_n = ~rts_n;
      write = ($urandom_range(0, 2) == 0);
      dat   = 8'($urandom);
      step();
    end
    write = 1'b0;
    rts_n = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trng_serial_tx.md
# trng_serial_tx

Byte-serial transmitter at the output of the TRNG capture path. It accepts one byte at a time from the FIFO drain logic through a single-entry holding register. It sends each byte on an 8N1 asynchronous serial line, gated by the host's active-low RTS. It also raises a one-cycle pulse after every FRAME_BYTES bytes so the top level can count dumped frames.

## Interface
- CLK_DIV, 4: clock cycles per serial bit; must be ≥ 2.
- STOP_BITS, 1: number of stop bits; allowed values are 1 or 2.
- FRAME_BYTES, 256: number of bytes per frame; must be ≥ 1.
- i_clk  in  1  single system clock; every register is clocked on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_dat  in  8  byte to send; sampled on the write edge.
- i_write  in  1  write strobe; accepted only when o_ready=1.
- i_serial_rts_n  in  1  host ready-to-receive, active low, asynchronous to i_clk.
- o_ready  out  1  holding register empty; reset value 1.
- o_serial_data  out  1  serial line, idles high; reset value 1.
- o_busy  out  1  FSM is not in IDLE; reset value 0.
- o_new_frame  out  1  single-cycle pulse at the end of the last byte of each frame; reset value 0.

## Operation
- **RTS synchroniser:** 2-flop synchroniser on i_serial_rts_n, both flops reset to 1. rts_ok = synchronised value == 0.
- **Holding register**
  - i_write & o_ready captures i_dat into the holding register; hold_full becomes 1 and o_ready becomes 0 on that edge.
  - i_write while o_ready=0 is ignored: no overwrite and no error.
  - The holding register is freed on the edge that moves its byte into the shift register. o_ready=1 from the following cycle.
  - o_ready = ~hold_full, taken from a register.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: o_serial_data=1. If hold_full & rts_ok: load the shift register, free the holding register, go to START.
  - START: o_serial_data=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: o_serial_data=shift[0], LSB first. Each bit lasts CLK_DIV cycles, then the register shifts right. After bit 7 the FSM goes to STOP.
  - STOP: o_serial_data=1 for STOP_BITS*CLK_DIV cycles. On the last cycle:
    - If hold_full & rts_ok: load the next byte and go directly to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- **RTS rules**
  - RTS is sampled only at the IDLE-to-START and STOP-to-START decision points.
  - Deasserting RTS mid-byte never aborts or truncates the byte in flight.
  - A byte held in the holding register waits indefinitely for rts_ok.
- **Counters**
  - Baud counter: width clog2(CLK_DIV); counts 0..CLK_DIV-1 and wraps at each bit boundary.
  - Stop counter: counts through STOP_BITS bits.
  - Bit index: 3 bits.
  - Byte counter: width clog2(FRAME_BYTES)+1; increments on the last STOP cycle.
  - When the byte counter reaches FRAME_BYTES-1 on that cycle, it wraps to 0 and o_new_frame is registered high for exactly one cycle.
  - With FRAME_BYTES=1, o_new_frame pulses after every byte.
- **Reset mid-operation:** asserting i_reset_n low has immediate effect:
  - o_serial_data=1, FSM goes to IDLE, o_busy=0, o_ready=1;
  - the holding register and shift register are discarded;
  - the byte counter returns to 0, o_new_frame=0, and the RTS synchroniser flops return to 1.
- Deassertion of reset is taken synchronously by the surrounding logic. The first i_write is accepted on the first clock edge after i_reset_n rises.

## Timing
- **Write to line:** in IDLE with rts_ok already 1, an i_write captured at edge E0 gives:
  - START entered, o_serial_data=0 and o_busy=1 after edge E1;
  - o_ready=0 after E0 and o_ready=1 again after E2.
- **RTS latency:** a falling edge on i_serial_rts_n affects decisions 2–3 clocks later.
- **Frame length:** each serial frame is exactly (9+STOP_BITS)*CLK_DIV cycles from the first start-bit cycle to the last stop-bit cycle.
- **Throughput:** with the holding register refilled before the STOP end, the next start bit follows the last stop cycle directly. Sustained rate is one byte per (9+STOP_BITS)*CLK_DIV cycles.
- **Pulse alignment:** o_new_frame is high in the cycle after the last STOP cycle of the frame's final byte. That is the same cycle in which the line is idle high, or in which the next start bit begins.
- **Outputs:** all outputs come directly from registers, with no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold i_reset_n=0 with random inputs, then release -> o_serial_data=1, o_ready=1, o_busy=0, o_new_frame=0 throughout.
- **Single byte:** CLK_DIV=4, STOP_BITS=1, rts_n=0, write 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; start bit low 1 cycle after the write edge; o_busy returns to 0 after 40 cycles.
- **Back-to-back:** write 0x00, then write 0xFF as soon as o_ready=1 -> exactly 80 cycles of framing with no idle cycle between the two frames; the third write is held until o_ready=1.
- **Flow control:** rts_n=1, write 0x3C -> line stays high for 100 cycles with o_ready=0; drop rts_n -> start bit within 3 cycles. Raise rts_n mid-data -> the byte still completes, and the next held byte waits.
- **Framing:** FRAME_BYTES=4, send 9 bytes -> o_new_frame pulses exactly twice, one cycle each, after bytes 4 and 8.
- **Mid-byte reset:** assert i_reset_n=0 during data bit 3 -> o_serial_data=1 immediately (asynchronously); after release, a fresh 0x81 is sent correctly and the byte counter restarts from 0.
